// File: rtl/tia_biphase_pkg.sv
// Shared definitions for the TIA two-phase clock generator and decoder:
// FSM encoding, default phase timing and the nominal period helper.
package tia_biphase_pkg;

  typedef enum logic [2:0] {
    StHunt,
    StP1,
    StGap1,
    StP2,
    StGap2
  } state_e;

  localparam int unsigned DefHighLen   = 1;
  localparam int unsigned DefGapLen    = 1;
  localparam int unsigned DefLockCount = 4;

  // One full phi1/gap/phi2/gap sequence, in master clock cycles.
  function automatic int unsigned nominal_period(input int unsigned high_len,
                                                 input int unsigned gap_len);
    return 2 * (high_len + gap_len);
  endfunction

endpackage

// File: rtl/tia_biphase_decoder_if.sv
// Phase inputs and decoded status outputs of the biphase decoder.
// master = the side that drives phi1/phi2, slave = the decoder.
interface tia_biphase_decoder_if #(
  parameter int unsigned CNT_W = 8
) ();

  logic             phi1;
  logic             phi2;
  logic             err_clr;
  logic             p1_stb;
  logic             p2_stb;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] cycles;

  modport master (
    output phi1,
    output phi2,
    output err_clr,
    input  p1_stb,
    input  p2_stb,
    input  locked,
    input  err,
    input  cycles
  );

  modport slave (
    input  phi1,
    input  phi2,
    input  err_clr,
    output p1_stb,
    output p2_stb,
    output locked,
    output err,
    output cycles
  );

endinterface

// File: rtl/tia_phase_edge.sv
// Registers one phase input and reports its rise/fall against the previous sample.
module tia_phase_edge (
  input  logic clk,
  input  logic r,
  input  logic phase,
  output logic rise,
  output logic fall
);

  logic phase_q;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase;
    end
  end

  assign rise = phase & ~phase_q;
  assign fall = ~phase & phase_q;

endmodule

// File: rtl/tia_biphase_decoder.sv
// Checks the phi1/phi2 pair against the non-overlapping sequence and emits
// registered phase strobes, lock status, a sticky error and a locked cycle count.
module tia_biphase_decoder
  import tia_biphase_pkg::*;
#(
  parameter int unsigned HIGH_LEN   = DefHighLen,
  parameter int unsigned GAP_LEN    = DefGapLen,
  parameter int unsigned LOCK_COUNT = DefLockCount,  // must be >= 1
  parameter int unsigned CNT_W      = 8
) (
  input logic                    clk,
  input logic                    r,
  tia_biphase_decoder_if.slave   bus
);

  localparam int unsigned LenMax = (HIGH_LEN > GAP_LEN) ? HIGH_LEN : GAP_LEN;
  localparam int unsigned LenW   = $clog2(LenMax + 1);
  localparam int unsigned GoodW  = $clog2(LOCK_COUNT + 1);
  localparam logic [GoodW-1:0] GoodMax = GoodW'(LOCK_COUNT);

  state_e           state_q, state_d;
  logic [LenW-1:0]  len_q, len_d;
  logic [GoodW-1:0] good_q, good_d;
  logic             p1_stb_q, p1_stb_d;
  logic             p2_stb_q, p2_stb_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic p1_rise, p1_fall, p2_rise, p2_fall;
  logic hi_done, gap_done;
  logic viol, p1_acc, p2_acc, wrap;

  tia_phase_edge u_edge_phi1 (
    .clk   (clk),
    .r     (r),
    .phase (bus.phi1),
    .rise  (p1_rise),
    .fall  (p1_fall)
  );

  tia_phase_edge u_edge_phi2 (
    .clk   (clk),
    .r     (r),
    .phase (bus.phi2),
    .rise  (p2_rise),
    .fall  (p2_fall)
  );

  // len_q counts samples after the entry sample, so the current sample is the
  // (len_q+1)-th of the state; a phase may end only when that equals its length.
  assign hi_done  = (32'(len_q) + 32'd1) == HIGH_LEN;
  assign gap_done = (32'(len_q) + 32'd1) == GAP_LEN;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q  <= StHunt;
      len_q    <= '0;
      good_q   <= '0;
      p1_stb_q <= 1'b0;
      p2_stb_q <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      good_q   <= good_d;
      p1_stb_q <= p1_stb_d;
      p2_stb_q <= p2_stb_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      cycles_q <= cycles_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    viol    = 1'b0;
    p1_acc  = 1'b0;
    p2_acc  = 1'b0;
    wrap    = 1'b0;

    unique case (state_q)
      StHunt: begin
        if (p1_rise && !bus.phi2) begin
          state_d = StP1;
          len_d   = '0;
          p1_acc  = 1'b1;
        end
      end
      StP1: begin
        if (bus.phi2) begin
          viol = 1'b1;
        end else if (bus.phi1) begin
          if (hi_done) viol = 1'b1;
          else         len_d = len_q + LenW'(1);
        end else if (p1_fall && hi_done) begin
          state_d = StGap1;
          len_d   = '0;
        end else begin
          viol = 1'b1;
        end
      end
      StGap1: begin
        if (bus.phi1) begin
          viol = 1'b1;
        end else if (p2_rise) begin
          if (gap_done) begin
            state_d = StP2;
            len_d   = '0;
            p2_acc  = 1'b1;
          end else begin
            viol = 1'b1;
          end
        end else if (gap_done) begin
          viol = 1'b1;
        end else begin
          len_d = len_q + LenW'(1);
        end
      end
      StP2: begin
        if (bus.phi1) begin
          viol = 1'b1;
        end else if (bus.phi2) begin
          if (hi_done) viol = 1'b1;
          else         len_d = len_q + LenW'(1);
        end else if (p2_fall && hi_done) begin
          state_d = StGap2;
          len_d   = '0;
        end else begin
          viol = 1'b1;
        end
      end
      StGap2: begin
        if (bus.phi2) begin
          viol = 1'b1;
        end else if (p1_rise) begin
          if (gap_done) begin
            state_d = StP1;
            len_d   = '0;
            p1_acc  = 1'b1;
            wrap    = 1'b1;
          end else begin
            viol = 1'b1;
          end
        end else if (gap_done) begin
          viol = 1'b1;
        end else begin
          len_d = len_q + LenW'(1);
        end
      end
      default: begin
        state_d = StHunt;
        len_d   = '0;
      end
    endcase

    if (viol) begin
      state_d = StHunt;
      len_d   = '0;
    end
  end

  always_comb begin
    good_d = good_q;
    if (viol) begin
      good_d = '0;
    end else if (wrap && good_q != GoodMax) begin
      good_d = good_q + GoodW'(1);
    end

    // Lock follows the saturated good count, so it rises with the strobe that completes it.
    locked_d = (good_d == GoodMax);
    p1_stb_d = p1_acc;
    p2_stb_d = p2_acc;
    cycles_d = cycles_q + CNT_W'(p1_acc & locked_q);
    // Overlap is flagged even while hunting; a new violation beats err_clr.
    err_d    = viol | (bus.phi1 & bus.phi2) | (err_q & ~bus.err_clr);
  end

  assign bus.p1_stb = p1_stb_q;
  assign bus.p2_stb = p2_stb_q;
  assign bus.locked = locked_q;
  assign bus.err    = err_q;
  assign bus.cycles = cycles_q;

endmodule
